// File: rtl/alu_shift_pipe.sv
// rtl/alu_shift_pipe.sv - two-stage pipelined ALU/shifter with valid/ready handshake
// Optional feature macro: ARITH_SHIFT_EN (arithmetic right shift via shift_arith).
// Stage 1 registers the conditioned operands; stage 2 registers result and flags.
module alu_shift_pipe #(
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           src1,
  input  logic [WIDTH-1:0]           src2,
  input  logic                       invert_a,
  input  logic                       invert_b,
  input  logic [1:0]                 operation,
  input  logic                       unit_sel,
  input  logic                       left_right,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  input  logic                       shift_arith,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           result,
  output logic                       zero,
  output logic                       overflow
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  // Stage 1 state: conditioned operands plus everything stage 2 needs.
  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_a_q, s1_a_d;
  logic [WIDTH-1:0]   s1_b_q, s1_b_d;
  logic [WIDTH-1:0]   s1_src2_q, s1_src2_d;
  logic               s1_cin_q, s1_cin_d;
  logic [1:0]         s1_op_q, s1_op_d;
  logic               s1_unit_q, s1_unit_d;
  logic               s1_left_q, s1_left_d;
  logic [SHAMT_W-1:0] s1_shamt_q, s1_shamt_d;
  logic               s1_arith_q, s1_arith_d;

  // Stage 2 state: this is the output register.
  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               overflow_q, overflow_d;

  logic s2_adv;
  logic s1_adv;

  // Stage 2 datapath results computed from stage 1 registers.
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] calc_res;
  logic             calc_ovf;

  // A stage moves forward when its downstream slot is empty or draining.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
  end

  // Stage 1 next state: capture a new request whenever the stage can advance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_src2_d  = s1_src2_q;
    s1_cin_d   = s1_cin_q;
    s1_op_d    = s1_op_q;
    s1_unit_d  = s1_unit_q;
    s1_left_d  = s1_left_q;
    s1_shamt_d = s1_shamt_q;
    s1_arith_d = s1_arith_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d     = invert_a ? ~src1 : src1;
        s1_b_d     = invert_b ? ~src2 : src2;
        s1_src2_d  = src2;
        s1_cin_d   = invert_b;
        s1_op_d    = operation;
        s1_unit_d  = unit_sel;
        s1_left_d  = left_right;
        s1_shamt_d = shamt;
        s1_arith_d = shift_arith;
      end
    end
  end

  // Adder shared by ADD and SLT; carry-in doubles as the subtract bit.
  always_comb begin
    sum     = s1_a_q + s1_b_q + {{(WIDTH-1){1'b0}}, s1_cin_q};
    add_ovf = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
  end

`ifdef ARITH_SHIFT_EN
  // Shifter: right shifts sign-fill when shift_arith is set.
  always_comb begin
    if (s1_left_q) begin
      shift_res = s1_src2_q << s1_shamt_q;
    end else if (s1_arith_q) begin
      shift_res = $unsigned($signed(s1_src2_q) >>> s1_shamt_q);
    end else begin
      shift_res = s1_src2_q >> s1_shamt_q;
    end
  end
`else
  // Shifter: logical only; the captured shift_arith bit is deliberately dropped.
  logic unused_arith;
  assign unused_arith = s1_arith_q;

  always_comb begin
    if (s1_left_q) begin
      shift_res = s1_src2_q << s1_shamt_q;
    end else begin
      shift_res = s1_src2_q >> s1_shamt_q;
    end
  end
`endif

  // Select the unit result and its overflow flag.
  always_comb begin
    calc_res = '0;
    calc_ovf = 1'b0;
    if (s1_unit_q) begin
      calc_res = shift_res;
    end else begin
      case (s1_op_q)
        OP_AND: calc_res = s1_a_q & s1_b_q;
        OP_OR:  calc_res = s1_a_q | s1_b_q;
        OP_ADD: begin
          calc_res = sum;
          calc_ovf = add_ovf;
        end
        OP_SLT: begin
          calc_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
          calc_ovf = add_ovf;
        end
        default: calc_res = '0;
      endcase
    end
  end

  // Stage 2 next state: load on advance, otherwise hold the presented result.
  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d   = calc_res;
        zero_d     = (calc_res == '0);
        overflow_d = calc_ovf;
      end
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_src2_q  <= '0;
      s1_cin_q   <= 1'b0;
      s1_op_q    <= 2'b00;
      s1_unit_q  <= 1'b0;
      s1_left_q  <= 1'b0;
      s1_shamt_q <= '0;
      s1_arith_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_src2_q  <= s1_src2_d;
      s1_cin_q   <= s1_cin_d;
      s1_op_q    <= s1_op_d;
      s1_unit_q  <= s1_unit_d;
      s1_left_q  <= s1_left_d;
      s1_shamt_q <= s1_shamt_d;
      s1_arith_q <= s1_arith_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_shift_pipe.sv
// tb/tb_alu_shift_pipe.sv - scoreboard bench for alu_shift_pipe (WIDTH = 32)
module tb_alu_shift_pipe;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  src1;
  logic [W-1:0]  src2;
  logic          invert_a;
  logic          invert_b;
  logic [1:0]    operation;
  logic          unit_sel;
  logic          left_right;
  logic [4:0]    shamt;
  logic          shift_arith;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          overflow;

  int tests_run    = 0;
  int tests_failed = 0;
  int pops         = 0;

  logic [33:0] exp_q[$];
  logic [33:0] mon_exp;

  always #5 clk = ~clk;

  alu_shift_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .invert_a(invert_a), .invert_b(invert_b),
    .operation(operation), .unit_sel(unit_sel), .left_right(left_right),
    .shamt(shamt), .shift_arith(shift_arith), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .overflow(overflow)
  );

  // Reference model: returns {overflow, zero, result} using full-precision arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a_in, input logic [31:0] b_in,
                                        input logic ia, input logic ib, input logic [1:0] op,
                                        input logic unit, input logic lr, input logic [4:0] sh,
                                        input logic ar);
    logic [31:0] a, b, r, ones;
    logic        ov;
    longint      sa, sb, ss;
    ones = 32'hFFFF_FFFF;
    ov   = 1'b0;
    r    = '0;
    if (unit) begin
      if (lr) r = b_in << sh;
      else begin
        r = b_in >> sh;
`ifdef ARITH_SHIFT_EN
        if (ar && b_in[31]) r = r | ~(ones >> sh);
`else
        if (ar && 1'b0) r = ones;
`endif
      end
    end else begin
      a  = ia ? ~a_in : a_in;
      b  = ib ? ~b_in : b_in;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ss = sa + sb + (ib ? 64'sd1 : 64'sd0);
      case (op)
        2'b00: r = a & b;
        2'b01: r = a | b;
        2'b10: begin
          r  = ss[31:0];
          ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end
        default: begin
          r  = {31'b0, (ss < 0)};
          ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end
      endcase
    end
    return {ov, (r == 32'h0), r};
  endfunction

  // Output monitor: every transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_output: got result=%h, required no output", result);
      end else begin
        mon_exp = exp_q.pop_front();
        pops++;
        if ({overflow, zero, result} !== mon_exp) begin
          tests_failed++;
          $display("FAIL result_check: got ovf=%b zero=%b result=%h, required ovf=%b zero=%b result=%h",
                   overflow, zero, result, mon_exp[33], mon_exp[32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic ia,
                         input logic ib, input logic [1:0] op, input logic unit,
                         input logic lr, input logic [4:0] sh, input logic ar);
    int waited = 0;
    src1 = a; src2 = b; invert_a = ia; invert_b = ib; operation = op;
    unit_sel = unit; left_right = lr; shamt = sh; shift_arith = ar;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", waited);
    end else begin
      exp_q.push_back(model(a, b, ia, ib, op, unit, lr, sh, ar));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    src1 = '0; src2 = '0; invert_a = 0; invert_b = 0; operation = 2'b00;
    unit_sel = 0; left_right = 0; shamt = '0; shift_arith = 0;
    #1;
    tests_run++;
    if ({out_valid, zero, overflow, result} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b zero=%b ovf=%b result=%h, required all 0",
               out_valid, zero, overflow, result);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_add_latency();
    send_op(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 2'b10, 0, 0, 5'd0, 0);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_early: got out_valid=%b one cycle after accept, required 0", out_valid);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, overflow, zero, result} !== {1'b1, 1'b1, 1'b0, 32'h8000_0000}) begin
      tests_failed++;
      $display("FAIL latency_add: got valid=%b ovf=%b zero=%b result=%h, required 1 1 0 80000000",
               out_valid, overflow, zero, result);
    end
    drain();
  endtask

  task automatic test_sub_slt();
    send_op(32'h0000_0005, 32'h0000_0005, 0, 1, 2'b10, 0, 0, 5'd0, 0);
    send_op(32'h8000_0000, 32'h0000_0001, 0, 1, 2'b11, 0, 0, 5'd0, 0);
    send_op(32'h0000_0001, 32'h8000_0000, 0, 1, 2'b11, 0, 0, 5'd0, 0);
    send_op(32'h8000_0000, 32'h0000_0001, 0, 1, 2'b10, 0, 0, 5'd0, 0);
    drain();
  endtask

  task automatic test_shift();
    send_op(32'h1234_5678, 32'h8000_0001, 1, 1, 2'b10, 1, 1, 5'd4, 0);
    send_op(32'h0, 32'h8000_0001, 0, 0, 2'b00, 1, 0, 5'd4, 0);
    send_op(32'h0, 32'h8000_0001, 0, 0, 2'b00, 1, 0, 5'd4, 1);
    send_op(32'h0, 32'h8000_0001, 0, 0, 2'b00, 1, 1, 5'd4, 1);
    send_op(32'h0, 32'hA5A5_0F0F, 0, 0, 2'b00, 1, 0, 5'd0, 1);
    send_op(32'h0, 32'h8000_0000, 0, 0, 2'b00, 1, 0, 5'd31, 1);
    drain();
  endtask

  task automatic test_logic();
    send_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 1, 2'b00, 0, 0, 5'd0, 0);
    send_op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 1, 2'b01, 0, 0, 5'd0, 0);
    send_op(32'hF0F0_F0F0, 32'h0F0F_0F0F, 0, 0, 2'b00, 0, 0, 5'd0, 0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic        saw_block = 1'b0;
    logic        have_hold = 1'b0;
    logic [31:0] held = '0;
    int          pops_start = pops;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)));
        end
      end
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = (c < 3) || (c > 6);
          @(negedge clk);
          if (!in_ready) saw_block = 1'b1;
          if (!out_ready && out_valid) begin
            if (have_hold) begin
              tests_run++;
              if (result !== held) begin
                tests_failed++;
                $display("FAIL stall_hold: got result=%h, required %h", result, held);
              end
            end else begin
              held      = result;
              have_hold = 1'b1;
            end
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    tests_run++;
    if (saw_block !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_in_ready: got in_ready never low, required low while full");
    end
    drain();
    tests_run++;
    if (pops - pops_start != 8) begin
      tests_failed++;
      $display("FAIL stream_count: got %0d results, required 8", pops - pops_start);
    end
  endtask

  task automatic test_mid_reset();
    logic stale = 1'b0;
    out_ready = 1'b0;
    send_op(32'h0000_0001, 32'h0000_0002, 0, 0, 2'b10, 0, 0, 5'd0, 0);
    send_op(32'h0000_0055, 32'h0000_00AA, 0, 0, 2'b01, 0, 0, 5'd0, 0);
    tests_run++;
    if ({out_valid, in_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL pipe_full: got out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, result} !== 33'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got out_valid=%b result=%h, required 0 0", out_valid, result);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    tests_run++;
    if (stale !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_after_reset: got out_valid=1 after release, required 0");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_sub_slt();
    test_shift();
    test_logic();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog");
  end

endmodule
